// File: rtl/fv_mul_arbiter.sv
// fv_mul_arbiter: packet-granular round-robin arbiter in front of one shared
// negacyclic polynomial multiplier. A grant covers one whole polynomial:
// N input beats forwarded to the multiplier, then N result beats routed back.
// Optional watchdog on the result phase: define MUL_ARB_WDOG_EN.
module fv_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int N    = 4,
    parameter int QW   = 5,
    parameter int UW   = 1,
    parameter int WDOG = 64
) (
    input  logic                      clk,
    input  logic                      s_rst,
    input  logic [NREQ*QW-1:0]        p_data,
    input  logic [NREQ*UW-1:0]        u_data,
    input  logic [NREQ-1:0]           p_vld,
    input  logic [NREQ-1:0]           u_vld,
    input  logic [NREQ-1:0]           p_last,
    input  logic [NREQ-1:0]           u_last,
    output logic [NREQ-1:0]           p_rdy,
    output logic [NREQ-1:0]           u_rdy,
    output logic [QW-1:0]             m_p_data,
    output logic [UW-1:0]             m_u_data,
    output logic                      m_vld,
    output logic                      m_last,
    input  logic                      m_rdy,
    input  logic [QW-1:0]             r_data,
    input  logic                      r_vld,
    input  logic                      r_last,
    output logic [QW-1:0]             z_data,
    output logic [NREQ-1:0]           z_vld,
    output logic [NREQ-1:0]           z_last,
    output logic [$clog2(NREQ)-1:0]   gnt_id,
    output logic                      busy,
    output logic                      err_len,
    output logic                      err_wdog
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_WAIT} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   rr_ptr, rr_nxt, gnt_nxt, win, idx;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [NREQ-1:0] req;
    logic            found, fire, any_last, beat_last, err_len_nxt, wdog_hit;

    assign req  = p_vld & u_vld;
    assign busy = (state != ST_IDLE);

    // Rotating-priority search: first requester at or after rr_ptr.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = rr_ptr + GW'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // State register plus grant, pointer, beat counter and length-error pulse.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            state   <= ST_IDLE;
            rr_ptr  <= '0;
            gnt_id  <= '0;
            cnt     <= '0;
            err_len <= 1'b0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_nxt;
            gnt_id  <= gnt_nxt;
            cnt     <= cnt_nxt;
            err_len <= err_len_nxt;
        end
    end

    // Next-state logic and the per-state routing of data, valid and ready.
    always_comb begin
        state_nxt   = state;
        rr_nxt      = rr_ptr;
        gnt_nxt     = gnt_id;
        cnt_nxt     = cnt;
        err_len_nxt = 1'b0;
        fire        = 1'b0;
        p_rdy       = '0;
        u_rdy       = '0;
        m_p_data    = '0;
        m_u_data    = '0;
        m_vld       = 1'b0;
        m_last      = 1'b0;
        z_data      = '0;
        z_vld       = '0;
        z_last      = '0;
        any_last    = p_last[gnt_id] | u_last[gnt_id];
        beat_last   = (cnt == CW'(N - 1));
        case (state)
            ST_IDLE: begin
                if (found) begin
                    gnt_nxt   = win;
                    rr_nxt    = win + GW'(1);
                    cnt_nxt   = '0;
                    state_nxt = ST_FEED;
                end
            end
            ST_FEED: begin
                m_p_data      = p_data[int'(gnt_id)*QW +: QW];
                m_u_data      = u_data[int'(gnt_id)*UW +: UW];
                m_vld         = req[gnt_id];
                m_last        = m_vld & beat_last;
                p_rdy[gnt_id] = m_rdy;
                u_rdy[gnt_id] = m_rdy;
                fire          = m_vld & m_rdy;
                if (fire) begin
                    cnt_nxt     = cnt + CW'(1);
                    // packet length is fixed at N; requester last only audited
                    err_len_nxt = any_last ^ beat_last;
                    if (beat_last) state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                z_data         = r_data;
                z_vld[gnt_id]  = r_vld;
                z_last[gnt_id] = r_vld & r_last;
                if ((r_vld && r_last) || wdog_hit) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef MUL_ARB_WDOG_EN
    localparam int WW = $clog2(WDOG + 1);
    logic [WW-1:0] wcnt;

    assign wdog_hit = (state == ST_WAIT) && !r_vld && (wcnt == WW'(WDOG - 1));

    // Result-phase silence counter; any result beat restarts it.
    always_ff @(posedge clk) begin
        if (s_rst || state != ST_WAIT || r_vld) wcnt <= '0;
        else                                    wcnt <= wcnt + WW'(1);
    end

    // One-cycle expiry pulse, coincident with the return to idle.
    always_ff @(posedge clk) begin
        if (s_rst) err_wdog <= 1'b0;
        else       err_wdog <= wdog_hit;
    end
`else
    assign wdog_hit = 1'b0;
    assign err_wdog = 1'b0;
`endif

endmodule

// File: tb/tb_fv_mul_arbiter.sv
// Directed self-checking bench for fv_mul_arbiter (NREQ=4, N=4, QW=5, UW=1).
// The multiplier is played by the bench: results are driven directly on r_*.
module tb_fv_mul_arbiter;

    localparam int NREQ = 4;
    localparam int N    = 4;
    localparam int QW   = 5;
    localparam int UW   = 1;
    localparam int WDOG = 64;

    logic                 clk = 1'b0;
    logic                 s_rst;
    logic [NREQ*QW-1:0]   p_data;
    logic [NREQ*UW-1:0]   u_data;
    logic [NREQ-1:0]      p_vld, u_vld, p_last, u_last, p_rdy, u_rdy;
    logic [QW-1:0]        m_p_data;
    logic [UW-1:0]        m_u_data;
    logic                 m_vld, m_last, m_rdy;
    logic [QW-1:0]        r_data;
    logic                 r_vld, r_last;
    logic [QW-1:0]        z_data;
    logic [NREQ-1:0]      z_vld, z_last;
    logic [1:0]           gnt_id;
    logic                 busy, err_len, err_wdog;

    int   checks   = 0;
    int   failures = 0;
    logic exp_err;

    always #5 clk = ~clk;

    fv_mul_arbiter #(.NREQ(NREQ), .N(N), .QW(QW), .UW(UW), .WDOG(WDOG)) dut (
        .clk(clk), .s_rst(s_rst),
        .p_data(p_data), .u_data(u_data),
        .p_vld(p_vld), .u_vld(u_vld), .p_last(p_last), .u_last(u_last),
        .p_rdy(p_rdy), .u_rdy(u_rdy),
        .m_p_data(m_p_data), .m_u_data(m_u_data),
        .m_vld(m_vld), .m_last(m_last), .m_rdy(m_rdy),
        .r_data(r_data), .r_vld(r_vld), .r_last(r_last),
        .z_data(z_data), .z_vld(z_vld), .z_last(z_last),
        .gnt_id(gnt_id), .busy(busy), .err_len(err_len), .err_wdog(err_wdog)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in an idle cycle with requester g asking; ends in the first WAIT cycle.
    task automatic feed(input int g, input logic [3:0] mask, input bit toggle);
        chk("idle_busy", busy, 0);
        chk("idle_rdy", p_rdy, 0);
        tick();
        chk("gnt_id", gnt_id, g);
        chk("feed_busy", busy, 1);
        exp_err = 1'b0;
        for (int k = 0; k < N; k++) begin
            p_data[g*QW +: QW] = QW'(g*8 + k + 1);
            u_data[g*UW +: UW] = UW'(k + g);
            p_last[g] = mask[k];
            u_last[g] = mask[k] && (k == N-1);
            m_rdy = 1'b1;
            #1;
            chk("err_len", err_len, exp_err);
            chk("m_p_data", m_p_data, g*8 + k + 1);
            chk("m_u_data", m_u_data, (k + g) % 2);
            chk("m_vld", m_vld, 1);
            chk("m_last", m_last, (k == N-1));
            chk("p_rdy", p_rdy, 1 << g);
            chk("u_rdy", u_rdy, 1 << g);
            tick();
            exp_err = mask[k] ^ (k == N-1);
            if (toggle && k < N-1) begin
                p_data[g*QW +: QW] = QW'(g*8 + k + 2);
                p_last[g] = 1'b0;
                u_last[g] = 1'b0;
                m_rdy = 1'b0;
                #1;
                chk("stall_err_len", err_len, exp_err);
                chk("stall_m_p_data", m_p_data, g*8 + k + 2);
                chk("stall_m_vld", m_vld, 1);
                chk("stall_p_rdy", p_rdy, 0);
                chk("stall_u_rdy", u_rdy, 0);
                tick();
                exp_err = 1'b0;
            end
        end
        p_last[g] = 1'b0;
        u_last[g] = 1'b0;
        chk("wait_err_len", err_len, exp_err);
        chk("wait_busy", busy, 1);
        chk("wait_p_rdy", p_rdy, 0);
    endtask

    // Returns N results with zero latency; ends in the following idle cycle.
    task automatic results(input int g);
        for (int j = 0; j < N; j++) begin
            r_vld  = 1'b1;
            r_data = QW'(20 + j + g);
            r_last = (j == N-1);
            #1;
            chk("z_data", z_data, 20 + j + g);
            chk("z_vld", z_vld, 1 << g);
            chk("z_last", z_last, (j == N-1) ? (1 << g) : 0);
            chk("res_busy", busy, 1);
            chk("res_p_rdy", p_rdy, 0);
            tick();
        end
        r_vld  = 1'b0;
        r_last = 1'b0;
        #1;
        chk("post_busy", busy, 0);
        chk("post_z_vld", z_vld, 0);
    endtask

    initial begin
        s_rst = 1'b1;
        p_data = '0; u_data = '0; p_vld = '0; u_vld = '0; p_last = '0; u_last = '0;
        m_rdy = 1'b0; r_data = '0; r_vld = 1'b0; r_last = 1'b0;
        tick();
        tick();
        s_rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_gnt_id", gnt_id, 0);
        chk("rst_p_rdy", p_rdy, 0);
        chk("rst_u_rdy", u_rdy, 0);
        chk("rst_m_vld", m_vld, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_p_data", m_p_data, 0);
        chk("rst_z_vld", z_vld, 0);
        chk("rst_z_last", z_last, 0);
        chk("rst_z_data", z_data, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_err_wdog", err_wdog, 0);

        // Single requester 2, continuous valid, m_rdy high.
        p_vld = 4'b0100; u_vld = 4'b0100; m_rdy = 1'b1;
        #1;
        feed(2, 4'b1000, 1'b0);
        p_vld = '0; u_vld = '0;
        results(2);

        // Reset during beat 2: pointer must return to 0 (it was 3).
        p_vld = 4'b0100; u_vld = 4'b0100;
        tick();
        chk("rst2_gnt", gnt_id, 2);
        tick();
        tick();
        s_rst = 1'b1;
        #1;
        chk("rst2_m_vld", m_vld, 1);
        tick();
        s_rst = 1'b0;
        p_vld = '0; u_vld = '0;
        #1;
        chk("rst2_busy", busy, 0);
        chk("rst2_gnt_id", gnt_id, 0);
        chk("rst2_p_rdy", p_rdy, 0);
        chk("rst2_u_rdy", u_rdy, 0);
        chk("rst2_z_vld", z_vld, 0);
        chk("rst2_err_len", err_len, 0);

        // All four requesting: order 0,1,2,3,0.
        p_vld = 4'hf; u_vld = 4'hf;
        for (int i = 0; i < 5; i++) begin
            feed(i % 4, 4'b1000, 1'b0);
            results(i % 4);
        end

        // m_rdy toggling on requester 1.
        p_vld = 4'b0010; u_vld = 4'b0010;
        feed(1, 4'b1000, 1'b1);
        p_vld = '0; u_vld = '0;
        results(1);

        // Early last on beat 1 (requester 3): one pulse.
        p_vld = 4'b1000; u_vld = 4'b1000;
        feed(3, 4'b1010, 1'b0);
        p_vld = '0; u_vld = '0;
        results(3);

        // Missing last on beat 3 (requester 0): one pulse.
        p_vld = 4'b0001; u_vld = 4'b0001;
        feed(0, 4'b0000, 1'b0);
        p_vld = '0; u_vld = '0;
        results(0);

        // No result after FEED (requester 1).
        p_vld = 4'b0010; u_vld = 4'b0010;
        feed(1, 4'b1000, 1'b0);
        p_vld = '0; u_vld = '0;
`ifdef MUL_ARB_WDOG_EN
        for (int c = 0; c < WDOG; c++) begin
            chk("wd_quiet", err_wdog, 0);
            chk("wd_busy", busy, 1);
            tick();
        end
        chk("wd_pulse", err_wdog, 1);
        chk("wd_idle", busy, 0);
        // rr_ptr stays at 2 across expiry, so 2 beats 0.
        p_vld = 4'b0101; u_vld = 4'b0101;
        #1;
        feed(2, 4'b1000, 1'b0);
        p_vld = '0; u_vld = '0;
        chk("wd_pulse_gone", err_wdog, 0);
        results(2);
`else
        repeat (70) tick();
        chk("nowd_busy", busy, 1);
        chk("nowd_err_wdog", err_wdog, 0);
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        #1;
        chk("nowd_rst_busy", busy, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
